// File: rtl/axi_rw_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite read/write arbiter.
// FSM state codes, AXI response codes and the fixed protection attribute.
package axi_rw_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT = 3'b000;

endpackage

// File: rtl/axi_lite_rw_arbiter_rr_arb2.sv
// Two-way round-robin selector: with both requesting, the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/axi_lite_rw_arbiter.sv
// Arbitrates two command ports onto one AXI4-Lite master, one transaction at a time,
// and reports data, response and bus latency per completion. DATA_W must be 32.
module axi_lite_rw_arbiter
  import axi_rw_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,

  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,

  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [CNT_W-1:0]      rsp_cycles,

  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  state_t              state_r;
  logic [1:0]          grant;
  logic                grant_id_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [1:0]          resp_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                aw_pend_r;
  logic                w_pend_r;

  logic                accept;
  logic                sel_id;
  logic                aw_done;
  logic                w_done;
  logic                busy;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // grant_id_r doubles as the round-robin "last granted" pointer.
  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .last  (grant_id_r),
    .grant (grant)
  );

  assign accept    = (state_r == ST_IDLE) && (grant != 2'b00);
  assign sel_id    = grant[1];
  assign sel_addr  = sel_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = sel_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // A channel is finished once its handshake has happened, now or earlier.
  assign aw_done = ~aw_pend_r | m_awready;
  assign w_done  = ~w_pend_r  | m_wready;

  assign busy = (state_r == ST_WR_REQ) || (state_r == ST_WR_RESP) ||
                (state_r == ST_RD_REQ) || (state_r == ST_RD_DATA);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    if (!ARESETN) begin
      state_r    <= ST_IDLE;
      grant_id_r <= 1'b1;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      resp_r     <= RESP_OKAY;
      aw_pend_r  <= 1'b0;
      w_pend_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            addr_r     <= sel_addr;
            wdata_r    <= sel_wdata;
            grant_id_r <= sel_id;
            rdata_r    <= '0;
            resp_r     <= RESP_OKAY;
            if (req_write[sel_id]) begin
              state_r   <= ST_WR_REQ;
              aw_pend_r <= 1'b1;
              w_pend_r  <= 1'b1;
            end else begin
              state_r <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (aw_pend_r && m_awready) aw_pend_r <= 1'b0;
          if (w_pend_r && m_wready)   w_pend_r  <= 1'b0;
          if (aw_done && w_done)      state_r   <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (m_bvalid) begin
            resp_r  <= m_bresp;
            state_r <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (m_arready) state_r <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (m_rvalid) begin
            rdata_r <= m_rdata;
            resp_r  <= m_rresp;
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_r <= '0;
    end else if (accept) begin
      cnt_r <= '0;
    end else if (busy && (cnt_r != '1)) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Gated by ARESETN so no ready reaches a requester while reset is held.
  assign req_ready  = ((state_r == ST_IDLE) && ARESETN) ? grant : 2'b00;
  assign rsp_valid  = (state_r == ST_DONE) ? {grant_id_r, ~grant_id_r} : 2'b00;
  assign rsp_rdata  = rdata_r;
  assign rsp_resp   = resp_r;
  assign rsp_cycles = cnt_r;

  assign m_awaddr  = addr_r;
  assign m_awprot  = AXI_PROT;
  assign m_awvalid = aw_pend_r;
  assign m_wdata   = wdata_r;
  assign m_wstrb   = '1;
  assign m_wvalid  = w_pend_r;
  assign m_bready  = (state_r == ST_WR_RESP);
  assign m_araddr  = addr_r;
  assign m_arprot  = AXI_PROT;
  assign m_arvalid = (state_r == ST_RD_REQ);
  assign m_rready  = (state_r == ST_RD_DATA);

endmodule

// File: tb/tb_axi_lite_rw_arbiter.sv
// Directed bench for axi_lite_rw_arbiter with a small AXI4-Lite slave model
// whose write-data delay, response codes and read stall are steerable.
module tb_axi_lite_rw_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic                 ACLK = 1'b0;
  logic                 ARESETN = 1'b0;
  logic [1:0]           req_valid, req_write, req_ready, rsp_valid;
  logic [2*ADDR_W-1:0]  req_addr;
  logic [2*DATA_W-1:0]  req_wdata;
  logic [DATA_W-1:0]    rsp_rdata;
  logic [1:0]           rsp_resp;
  logic [CNT_W-1:0]     rsp_cycles;

  logic [ADDR_W-1:0]    m_awaddr, m_araddr;
  logic [2:0]           m_awprot, m_arprot;
  logic                 m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DATA_W-1:0]    m_wdata, m_rdata;
  logic [DATA_W/8-1:0]  m_wstrb;
  logic [1:0]           m_bresp, m_rresp;
  logic                 m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int n_cmp = 0;
  int n_err = 0;

  // slave steering knobs
  int         w_delay = 0;
  logic [1:0] bresp_mode = 2'b00;
  logic [1:0] rresp_mode = 2'b00;
  logic       r_stall = 1'b0;

  int   aw_age;
  logic aw_done, w_done;
  logic [31:0] mem [16];
  int aw_cnt = 0, w_cnt = 0, rsp_pulses = 0;

  logic aw_hs, w_hs, ar_hs;

  axi_lite_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_cycles(rsp_cycles),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 ACLK = ~ACLK;

  assign m_awready = 1'b1;
  assign m_arready = 1'b1;
  assign m_wready  = (w_delay == 0) || (aw_age >= w_delay);
  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign ar_hs = m_arvalid & m_arready;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  end

  always @(posedge ACLK) begin
    if (w_hs) mem[m_awaddr[5:2]] <= m_wdata;
    if (aw_hs) aw_cnt <= aw_cnt + 1;
    if (w_hs) w_cnt <= w_cnt + 1;
    if (rsp_valid != 2'b00) rsp_pulses <= rsp_pulses + 1;
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_bvalid <= 1'b0; m_bresp <= 2'b00;
      m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= 32'h0;
      aw_age <= 0; aw_done <= 1'b0; w_done <= 1'b0;
    end else begin
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (w_hs) aw_age <= 0;
      else if (aw_hs) aw_age <= 1;
      else if (aw_age != 0) aw_age <= aw_age + 1;
      if ((aw_hs || aw_done) && (w_hs || w_done)) begin
        m_bvalid <= 1'b1; m_bresp <= bresp_mode;
        aw_done <= 1'b0; w_done <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (ar_hs && !r_stall) begin
        m_rvalid <= 1'b1; m_rdata <= mem[m_araddr[5:2]]; m_rresp <= rresp_mode;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id*ADDR_W +: ADDR_W]  = addr;
    req_wdata[id*DATA_W +: DATA_W] = wd;
  endtask

  task automatic wait_rsp(input logic [1:0] exp, input string tag);
    int n;
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      @(posedge ACLK); #1;
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, exp);
  endtask

  initial begin
    logic [1:0] g;
    int aw0, w0, p0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;

    // reset state, with a requester pushing while reset is held
    repeat (2) @(posedge ACLK); #1;
    req_valid = 2'b01;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b000);
    check("rst_m_readies", {m_bready, m_rready}, 2'b00);
    check("rst_payload", {rsp_rdata, rsp_resp, rsp_cycles}, '0);
    req_valid = 2'b00;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // requester 0 writes 5 to 0x4 with a zero-wait slave
    issue(0, 1'b1, 32'h4, 32'h5);
    #1;
    check("t1_req_ready", req_ready, 2'b01);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    check("t1_aw_w_valid", {m_awvalid, m_wvalid}, 2'b11);
    check("t1_addr_data", {m_awaddr, m_wdata}, {32'h4, 32'h5});
    check("t1_strb_prot", {m_wstrb, m_awprot, m_arprot}, {4'hF, 3'b000, 3'b000});
    check("t1_busy_ready", req_ready, 2'b00);
    aw0 = aw_cnt; w0 = w_cnt;
    wait_rsp(2'b01, "t1");
    check("t1_resp", rsp_resp, 2'b00);
    check("t1_cycles", rsp_cycles, 2);
    check("t1_rdata", rsp_rdata, 32'h0);
    check("t1_hs_counts", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd1});
    @(posedge ACLK); #1;
    check("t1_done_one_cycle", rsp_valid, 2'b00);

    // requester 1 reads 0x4 back
    issue(1, 1'b0, 32'h4, 32'h0);
    #1;
    check("t2_req_ready", req_ready, 2'b10);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    check("t2_arvalid", {m_arvalid, m_araddr}, {1'b1, 32'h4});
    wait_rsp(2'b10, "t2");
    check("t2_rdata", rsp_rdata, 32'h5);
    check("t2_cycles", rsp_cycles, 2);
    @(posedge ACLK); #1;

    // round-robin from a fresh reset with both requesters always valid
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    issue(0, 1'b0, 32'h4, 32'h0);
    issue(1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      check($sformatf("t3_grant%0d", i), req_ready, g);
      @(posedge ACLK); #1;
      check($sformatf("t3_busy_ready%0d", i), req_ready, 2'b00);
      wait_rsp(g, $sformatf("t3_%0d", i));
      check($sformatf("t3_rdata%0d", i), rsp_rdata, 32'h5);
      @(posedge ACLK); #1;
    end
    req_valid = 2'b00;
    @(posedge ACLK); #1;

    // write data accepted three cycles after the address
    w_delay = 3;
    issue(0, 1'b1, 32'h8, 32'hA5A5_0001);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    aw0 = aw_cnt; w0 = w_cnt;
    wait_rsp(2'b01, "t4");
    check("t4_cycles", rsp_cycles, 5);
    check("t4_hs_counts", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd1});
    check("t4_resp", rsp_resp, 2'b00);
    w_delay = 0;
    @(posedge ACLK); #1;
    issue(1, 1'b0, 32'h8, 32'h0);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    wait_rsp(2'b10, "t4rb");
    check("t4rb_rdata", rsp_rdata, 32'hA5A5_0001);
    @(posedge ACLK); #1;

    // error responses pass through; write clears rdata
    rresp_mode = 2'b10;
    issue(0, 1'b0, 32'h4, 32'h0);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    wait_rsp(2'b01, "t5r");
    check("t5r_slverr", {rsp_resp, rsp_rdata}, {2'b10, 32'h5});
    rresp_mode = 2'b00;
    @(posedge ACLK); #1;
    bresp_mode = 2'b11;
    issue(1, 1'b1, 32'hC, 32'h77);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    wait_rsp(2'b10, "t5w");
    check("t5w_decerr", {rsp_resp, rsp_rdata}, {2'b11, 32'h0});
    bresp_mode = 2'b00;
    @(posedge ACLK); #1;

    // reset while waiting in RD_DATA abandons the read
    r_stall = 1'b1;
    issue(1, 1'b0, 32'h4, 32'h0);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    @(posedge ACLK); #1;
    check("t6_in_rd_data", {m_rready, m_arvalid, rsp_cycles}, {1'b1, 1'b0, 32'd1});
    p0 = rsp_pulses;
    ARESETN = 1'b0;
    #1;
    check("t6_rst_outputs", {m_rready, m_bready, m_arvalid, m_awvalid, m_wvalid, rsp_valid}, '0);
    check("t6_rst_payload", {rsp_rdata, rsp_resp, rsp_cycles}, '0);
    repeat (2) @(posedge ACLK); #1;
    ARESETN = 1'b1;
    r_stall = 1'b0;
    repeat (3) @(posedge ACLK); #1;
    check("t6_no_rsp", rsp_pulses - p0, 0);
    issue(0, 1'b0, 32'h4, 32'h0);
    issue(1, 1'b0, 32'h4, 32'h0);
    #1;
    check("t6_grant_after_rst", req_ready, 2'b01);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    wait_rsp(2'b01, "t6");
    check("t6_rdata", rsp_rdata, 32'h5);
    @(posedge ACLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
